des_iter_core: RTL and testbench

Iterative DES block cipher engine that produces one 64-bit block per operation by running the 16 Feistel rounds over several clock cycles. The number of rounds unrolled per cycle is set by a parameter, and the direction (encrypt or decrypt) is selectable per block. It sits between the host-side block buffer and the output buffer, with valid/ready handshakes on both sides. It supersedes standalone round-function usage with a complete, schedulable cipher core.

---
 rtl/des_pkg.sv | 157 +++++++++++++++
 rtl/des_round.sv | 27 ++
 rtl/des_iter_core.sv | 135 +++++++++++++
 tb/tb_des_iter_core.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes, key rotation schedule,
// FSM state encoding and the bit-permutation helpers used by the core.
package des_pkg;

  localparam int BLOCK_W  = 64;
  localparam int KEY_W    = 56;
  localparam int SUBKEY_W = 48;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } des_state_e;

  // Table entries are 1-based DES bit numbers, DES bit 1 being the MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Flattened S-boxes: index = box*64 + row*16 + column.
  localparam int SBOX [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

  // Decrypt rotates right starting from the PC1 output, walking K16 down to K1.
  localparam logic [1:0] ENC_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    logic [8:0]  idx;
    x = perm_e(r) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      b   = 6'(x >> (42 - 6 * i));
      idx = 9'(i * 64) + {3'b000, b[5], b[0], 4'b0000} + {5'b00000, b[4:1]};
      s   = {s[27:0], 4'(SBOX[idx])};
    end
    return perm_p(s);
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] sh,
                                        input logic right);
    logic [27:0] y;
    case ({right, sh})
      3'b001:  y = {x[26:0], x[27]};
      3'b010:  y = {x[25:0], x[27:26]};
      3'b101:  y = {x[0], x[27:1]};
      3'b110:  y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round including its key-schedule rotation step.
module des_round
  import des_pkg::*;
(
  input  logic [31:0] i_l,
  input  logic [31:0] i_r,
  input  logic [27:0] i_c,
  input  logic [27:0] i_d,
  input  logic        i_decrypt,
  input  logic [3:0]  i_round,
  output logic [31:0] o_l,
  output logic [31:0] o_r,
  output logic [27:0] o_c,
  output logic [27:0] o_d
);

  logic [1:0]  w_shift;
  logic [47:0] w_subkey;

  assign w_shift  = i_decrypt ? DEC_SHIFT[i_round] : ENC_SHIFT[i_round];
  assign o_c      = rot28(i_c, w_shift, i_decrypt);
  assign o_d      = rot28(i_d, w_shift, i_decrypt);
  assign w_subkey = perm_pc2({o_c, o_d});
  assign o_l      = i_r;
  assign o_r      = i_l ^ feistel(i_r, w_subkey);

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES engine, ROUNDS_PER_CYCLE chained rounds per clock.
// Optional key parity checking (out_err) is enabled by defining DES_PARITY_CHECK_EN.
module des_iter_core
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
`ifdef DES_PARITY_CHECK_EN
  output logic        out_err,
`endif
  output logic [1:0]  dbg_state
);

  localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and out_data is held while out_valid is high.
  des_state_e  r_state;
  logic [31:0] r_l, r_r;
  logic [27:0] r_c, r_d;
  logic        r_mode;
  logic [4:0]  r_cnt;
  logic [63:0] r_out;

  logic [63:0] w_ip;
  logic [55:0] w_pc1;
  logic        w_accept;
  logic [4:0]  w_cnt_next;

  logic [31:0] w_l [ROUNDS_PER_CYCLE+1];
  logic [31:0] w_r [ROUNDS_PER_CYCLE+1];
  logic [27:0] w_c [ROUNDS_PER_CYCLE+1];
  logic [27:0] w_d [ROUNDS_PER_CYCLE+1];

  assign w_ip       = perm_ip(in_data);
  assign w_pc1      = perm_pc1(in_key);
  assign in_ready   = (r_state == S_IDLE) && rst_n;
  assign w_accept   = in_valid && in_ready;
  assign w_cnt_next = r_cnt + STEP;
  assign out_valid  = (r_state == S_DONE);
  assign out_data   = r_out;
  assign dbg_state  = r_state;

  assign w_l[0] = r_l;
  assign w_r[0] = r_r;
  assign w_c[0] = r_c;
  assign w_d[0] = r_d;

  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    des_round u_round (
      .i_l       (w_l[g]),
      .i_r       (w_r[g]),
      .i_c       (w_c[g]),
      .i_d       (w_d[g]),
      .i_decrypt (r_mode),
      .i_round   (r_cnt[3:0] + 4'(g)),
      .o_l       (w_l[g+1]),
      .o_r       (w_r[g+1]),
      .o_c       (w_c[g+1]),
      .o_d       (w_d[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_l     <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_l     <= w_ip[63:32];
            r_r     <= w_ip[31:0];
            r_c     <= w_pc1[55:28];
            r_d     <= w_pc1[27:0];
            r_mode  <= in_decrypt;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_l   <= w_l[ROUNDS_PER_CYCLE];
          r_r   <= w_r[ROUNDS_PER_CYCLE];
          r_c   <= w_c[ROUNDS_PER_CYCLE];
          r_d   <= w_d[ROUNDS_PER_CYCLE];
          r_cnt <= w_cnt_next;
          // Final swap: FP is applied to R16 || L16.
          if (w_cnt_next == 5'd16) begin
            r_out   <= perm_fp({w_r[ROUNDS_PER_CYCLE], w_l[ROUNDS_PER_CYCLE]});
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DES_PARITY_CHECK_EN
  logic w_par_err;
  logic r_err;

  // DES keys use odd parity per byte; any even byte flags the key.
  always_comb begin
    w_par_err = 1'b0;
    for (int b = 0; b < 8; b++) w_par_err = w_par_err | ~(^8'(in_key >> (8 * b)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        r_err <= 1'b0;
    else if (w_accept) r_err <= w_par_err;
  end

  assign out_err = r_err;
`endif

endmodule

// File: tb/tb_des_iter_core.sv
// Directed-vector bench for des_iter_core: five instances (1,2,4,8,16 rounds per
// cycle) share the input side; latency is counted in edges including the accept edge.
module tb_des_iter_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_decrypt, out_ready;
  logic [63:0] in_data, in_key;
  logic        rdy  [5];
  logic        vld  [5];
  logic [63:0] dout [5];
  logic [1:0]  dbg  [5];
`ifdef DES_PARITY_CHECK_EN
  logic        err  [5];
`endif

  for (genvar g = 0; g < 5; g++) begin : g_dut
    des_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (rdy[g]),
      .in_data    (in_data),
      .in_key     (in_key),
      .in_decrypt (in_decrypt),
      .out_valid  (vld[g]),
      .out_ready  (out_ready),
      .out_data   (dout[g]),
`ifdef DES_PARITY_CHECK_EN
      .out_err    (err[g]),
`endif
      .dbg_state  (dbg[g])
    );
  end

  typedef struct {
    logic [63:0] data;
    logic [63:0] key;
    logic        dec;
    logic [63:0] exp;
    logic        err;
  } vec_t;

  vec_t        vecs [6];
  logic [63:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input int dut, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (rpc=%0d): got %h, expected %h", name, 1 << dut, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    int          lat [5];
    bit          done [5];
    bit          all_done;
    int          cnt;
    int          budget;
    logic [63:0] exp;
    exp_q.push_back(v.exp);
    @(negedge clk);
    in_data    = v.data;
    in_key     = v.key;
    in_decrypt = v.dec;
    in_valid   = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int g = 0; g < 5; g++) begin lat[g] = 0; done[g] = 1'b0; end
    cnt      = 1;
    budget   = 0;
    all_done = 1'b0;
    while (!all_done && budget < 40) begin
      @(negedge clk);
      all_done = 1'b1;
      for (int g = 0; g < 5; g++) begin
        if (!done[g] && vld[g] === 1'b1) begin done[g] = 1'b1; lat[g] = cnt; end
        all_done = all_done && done[g];
      end
      if (!all_done) begin @(posedge clk); cnt++; budget++; end
    end
    exp = exp_q.pop_front();
    for (int g = 0; g < 5; g++) begin
      check("latency", g, 64'(lat[g]), 64'((16 >> g) + 1));
      check("out_data", g, dout[g], exp);
      check("in_ready_in_done", g, 64'(rdy[g]), 64'd0);
`ifdef DES_PARITY_CHECK_EN
      check("out_err", g, 64'(err[g]), 64'(v.err));
`endif
    end
    // Stall downstream while upstream keeps offering blocks that must be ignored.
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      in_valid = c[0];
      in_data  = {$urandom, $urandom};
      in_key   = {$urandom, $urandom};
      @(negedge clk);
      for (int g = 0; g < 5; g++) begin
        check("hold_valid", g, 64'(vld[g]), 64'd1);
        check("hold_data", g, dout[g], exp);
        check("hold_in_ready", g, 64'(rdy[g]), 64'd0);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      check("ready_after_pop", g, 64'(rdy[g]), 64'd1);
      check("valid_after_pop", g, 64'(vld[g]), 64'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen [5];

    vecs[0] = '{64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405, 1'b0};
    vecs[1] = '{64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, 64'h0123456789ABCDEF, 1'b0};
    vecs[2] = '{64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0, 64'h0000000000000000, 1'b0};
    vecs[3] = '{64'h0000000000000000, 64'h0E329232EA6D0D73, 1'b1, 64'h8787878787878787, 1'b0};
    vecs[4] = '{64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7, 1'b1};
    vecs[5] = '{64'h8CA64DE9C1B123A7, 64'h0000000000000000, 1'b1, 64'h0000000000000000, 1'b1};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_decrypt = 1'b0;
    out_ready  = 1'b0;
    in_data    = '0;
    in_key     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      check("reset_in_ready", g, 64'(rdy[g]), 64'd0);
      check("reset_out_valid", g, 64'(vld[g]), 64'd0);
      check("reset_out_data", g, dout[g], 64'd0);
`ifdef DES_PARITY_CHECK_EN
      check("reset_out_err", g, 64'(err[g]), 64'd0);
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 5; g++) check("release_in_ready", g, 64'(rdy[g]), 64'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], (i == 0) ? 10 : 0);

    // Reset in the middle of a block: round 5 of the one-round-per-cycle instance.
    @(negedge clk);
    in_data    = vecs[2].data;
    in_key     = vecs[2].key;
    in_decrypt = vecs[2].dec;
    in_valid   = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      check("midrst_in_ready", g, 64'(rdy[g]), 64'd1);
      check("midrst_out_valid", g, 64'(vld[g]), 64'd0);
      check("midrst_out_data", g, dout[g], 64'd0);
      seen[g] = 0;
    end
    repeat (25) begin
      @(negedge clk);
      for (int g = 0; g < 5; g++) if (vld[g] !== 1'b0) seen[g]++;
    end
    for (int g = 0; g < 5; g++) check("midrst_no_result", g, 64'(seen[g]), 64'd0);

    run_vec(vecs[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
